// File: rtl/sal_arbiter_wrr_burst.sv
// Weighted round-robin arbiter with burst locking for one shared valid/ready channel.
// Optional per-requester burst counters: define SAL_ARBITER_WRR_STAT_EN.
module sal_arbiter_wrr_burst #(
  parameter int REQ_CNT      = 4,
  parameter int REQ_CNT_LG2  = $clog2(REQ_CNT),
  parameter int DATA_WIDTH   = 64,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REQ_CNT-1:0]      req_arr_i,
  input  logic [DATA_WIDTH-1:0]   data_arr_i [0:REQ_CNT-1],
  input  logic [REQ_CNT-1:0]      last_arr_i,
  input  logic [WEIGHT_WIDTH-1:0] weight_arr_i [0:REQ_CNT-1],
  output logic [REQ_CNT-1:0]      gnt_arr_o,
  output logic                    req_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    last_o,
  input  logic                    gnt_i
`ifdef SAL_ARBITER_WRR_STAT_EN
  ,
  input  logic                    stat_clr_i,
  output logic [31:0]             stat_burst_cnt_o [0:REQ_CNT-1]
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [REQ_CNT_LG2-1:0]  prev_q, prev_d;
  logic [REQ_CNT_LG2-1:0]  owner_q, owner_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    sel_vld;
  logic [REQ_CNT_LG2-1:0]  sel_idx;
  logic [REQ_CNT_LG2-1:0]  scan_idx;
  logic                    act;
  logic                    accept;
  logic                    done;
  logic [WEIGHT_WIDTH-1:0] wgt;
  logic [WEIGHT_WIDTH-1:0] wgt_m1;

  // Pick the candidate: locked owner, the credited previous winner, or a rotating scan.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    if (state_q == BURST) begin
      sel_vld = 1'b1;
      sel_idx = owner_q;
    end else if (credit_q != '0 && req_arr_i[prev_q]) begin
      sel_vld = 1'b1;
      sel_idx = prev_q;
    end else begin
      // The last step wraps back onto prev_q itself.
      for (int i = 1; i <= REQ_CNT; i++) begin
        scan_idx = prev_q + REQ_CNT_LG2'(i);
        if (!sel_vld && req_arr_i[scan_idx]) begin
          sel_vld = 1'b1;
          sel_idx = scan_idx;
        end
      end
    end
  end

  // Zero-latency downstream mux; everything forced low while in reset.
  always_comb begin
    act       = rst_n & sel_vld;
    req_o     = act & req_arr_i[sel_idx];
    data_o    = act ? data_arr_i[sel_idx] : '0;
    last_o    = act & last_arr_i[sel_idx];
    accept    = req_o & gnt_i;
    done      = accept & last_o;
    gnt_arr_o = accept ? (REQ_CNT'(1) << sel_idx) : '0;
  end

  // Weight of zero still buys one burst.
  always_comb begin
    wgt    = weight_arr_i[sel_idx];
    wgt_m1 = (wgt == '0) ? '0 : wgt - WEIGHT_WIDTH'(1);
  end

  // Next-state: lock on a non-last beat, settle credit on the last beat.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    if (accept) begin
      if (last_o) begin
        state_d = IDLE;
        if (sel_idx == prev_q && credit_q != '0) begin
          credit_d = credit_q - WEIGHT_WIDTH'(1);
        end else begin
          credit_d = wgt_m1;
          prev_d   = sel_idx;
        end
      end else if (state_q == IDLE) begin
        state_d = BURST;
        owner_d = sel_idx;
      end
    end
  end

  // Arbitration state; reset drops any lock at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= REQ_CNT_LG2'(REQ_CNT - 1);
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

`ifdef SAL_ARBITER_WRR_STAT_EN
  logic [31:0] cnt_q [0:REQ_CNT-1];

  // Saturating completed-burst counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_CNT; i++) begin
        if (stat_clr_i) begin
          cnt_q[i] <= '0;
        end else if (done && sel_idx == REQ_CNT_LG2'(i)
                     && cnt_q[i] != 32'hFFFF_FFFF) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  // Expose the counters.
  always_comb begin
    for (int i = 0; i < REQ_CNT; i++) begin
      stat_burst_cnt_o[i] = cnt_q[i];
    end
  end
`else
  logic unused_done;

  // Burst-completion pulse only feeds the optional counters.
  always_comb begin
    unused_done = done;
  end
`endif

endmodule

// File: tb/tb_sal_arbiter_wrr_burst.sv
// Directed bench for sal_arbiter_wrr_burst: vector table plus reset/stat sequences.
// Build with SAL_ARBITER_WRR_STAT_EN to also exercise the counters.
module tb_sal_arbiter_wrr_burst;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_arr_i;
  logic [DW-1:0] data_arr_i [0:N-1];
  logic [N-1:0]  last_arr_i;
  logic [WW-1:0] weight_arr_i [0:N-1];
  logic [N-1:0]  gnt_arr_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          gnt_i;
`ifdef SAL_ARBITER_WRR_STAT_EN
  logic          stat_clr_i;
  logic [31:0]   stat_burst_cnt_o [0:N-1];
`endif

  sal_arbiter_wrr_burst #(
    .REQ_CNT(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_arr_i(req_arr_i),
    .data_arr_i(data_arr_i),
    .last_arr_i(last_arr_i),
    .weight_arr_i(weight_arr_i),
    .gnt_arr_o(gnt_arr_o),
    .req_o(req_o),
    .data_o(data_o),
    .last_o(last_o),
    .gnt_i(gnt_i)
`ifdef SAL_ARBITER_WRR_STAT_EN
    ,
    .stat_clr_i(stat_clr_i),
    .stat_burst_cnt_o(stat_burst_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic        gnt;
    logic [15:0] w;
    logic [3:0]  egnt;
    logic        ereq;
    int          esel;
  } vec_t;

  vec_t tv [$];
  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] dpat(input int i);
    return 64'(i + 1) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic void add(input logic r, input logic [3:0] q,
                              input logic [3:0] l, input logic g,
                              input logic [15:0] w, input logic [3:0] eg,
                              input logic er, input int es);
    vec_t v;
    v.rst = r; v.req = q; v.last = l; v.gnt = g; v.w = w;
    v.egnt = eg; v.ereq = er; v.esel = es;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_w(input logic [15:0] w);
    for (int i = 0; i < N; i++) weight_arr_i[i] = w[i*4 +: 4];
  endtask

  task automatic chk_out(input string nm, input logic [3:0] eg,
                         input logic er, input int es,
                         input logic [3:0] l);
    logic [DW-1:0] ed;
    logic el;
    ed = (es >= 0) ? dpat(es) : '0;
    el = 1'b0;
    if (es >= 0) el = l[es];
    chk({nm, ".gnt"}, 64'(gnt_arr_o), 64'(eg));
    chk({nm, ".req"}, 64'(req_o), 64'(er));
    chk({nm, ".data"}, data_o, ed);
    chk({nm, ".last"}, 64'(last_o), 64'(el));
  endtask

  initial begin
    for (int i = 0; i < N; i++) data_arr_i[i] = dpat(i);
    rst_n = 1'b0;
    req_arr_i = 4'b1111;
    last_arr_i = 4'b1111;
    gnt_i = 1'b1;
    set_w(16'h1111);
`ifdef SAL_ARBITER_WRR_STAT_EN
    stat_clr_i = 1'b0;
`endif

    // plain round robin
    add(1, 4'hF, 4'hF, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b0010, 1, 1);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b0100, 1, 2);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b1000, 1, 3);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b0001, 1, 0);
    // weight 3 on requester 0
    add(1, 4'hF, 4'hF, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0010, 1, 1);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0100, 1, 2);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b1000, 1, 3);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 16'h1113, 4'b0001, 1, 0);
    // 4-beat burst from 0 with a stall, 1 waiting
    add(1, 4'b0011, 4'b0000, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0000, 0, 16'h1111, 4'b0000, 1, 0);
    add(0, 4'b0011, 4'b0000, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0000, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0011, 4'b0001, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0010, 4'b0010, 1, 16'h1111, 4'b0010, 1, 1);
    // owner bubble while 2 waits
    add(1, 4'b0101, 4'b0000, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, 16'h1111, 4'b0000, 0, 0);
    add(0, 4'b0100, 4'b0000, 1, 16'h1111, 4'b0000, 0, 0);
    add(0, 4'b0100, 4'b0000, 1, 16'h1111, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b0001, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0100, 4'b0100, 1, 16'h1111, 4'b0100, 1, 2);
    // wrap 3 -> 0, idle, stall without state change
    add(1, 4'b1000, 4'b1000, 1, 16'h1111, 4'b1000, 1, 3);
    add(0, 4'b0001, 4'b0001, 1, 16'h1111, 4'b0001, 1, 0);
    add(0, 4'b0000, 4'b0000, 1, 16'h1111, 4'b0000, 0, -1);
    add(0, 4'b0010, 4'b0010, 0, 16'h1111, 4'b0000, 1, 1);
    add(0, 4'b0110, 4'b0110, 1, 16'h1111, 4'b0010, 1, 1);

    // outputs held low during reset
    #1;
    chk_out("in_reset", 4'b0000, 1'b0, -1, 4'b0000);

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      if (tv[k].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      req_arr_i = tv[k].req;
      last_arr_i = tv[k].last;
      gnt_i = tv[k].gnt;
      set_w(tv[k].w);
      #1;
      chk_out($sformatf("vec%0d", k), tv[k].egnt, tv[k].ereq,
              tv[k].esel, tv[k].last);
    end

    // asynchronous reset mid-burst, then lowest requester wins
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_w(16'h1111);
    req_arr_i = 4'b0110;
    last_arr_i = 4'b0000;
    gnt_i = 1'b1;
    #1;
    chk("midrst.first", 64'(gnt_arr_o), 64'b0010);
    @(negedge clk);
    #1;
    chk("midrst.locked", 64'(gnt_arr_o), 64'b0010);
    rst_n = 1'b0;
    #1;
    chk_out("midrst.asserted", 4'b0000, 1'b0, -1, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req_arr_i = 4'b1100;
    last_arr_i = 4'b1100;
    #1;
    chk_out("midrst.after", 4'b0100, 1'b1, 2, 4'b1100);

`ifdef SAL_ARBITER_WRR_STAT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_arr_i = 4'b0010;
    last_arr_i = 4'b0010;
    for (int k = 0; k < 5; k++) @(negedge clk);
    req_arr_i = 4'b0000;
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("stat%0d", i), 64'(stat_burst_cnt_o[i]),
          (i == 1) ? 64'd5 : 64'd0);
    stat_clr_i = 1'b1;
    @(negedge clk);
    stat_clr_i = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("statclr%0d", i), 64'(stat_burst_cnt_o[i]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
